ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Downstream consumer of the decoded control bundle. It carries ID-stage control through the
//  ID/EX, EX/MEM and MEM/WB stage registers alongside the destination register number.
//  It also generates the hazard controls: EX-operand forwarding, load-use stall, multi-cycle
//  HI/LO (mult/div) stall, and flush on an EX-resolved redirect. It sits between the ID-stage
//  decoder and the datapath stage registers.
// PARAMETERS
//  MUL_LAT  4  cycles a mult/div occupies EX (>=1; 1 = no stall)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   synchronous reset, active-low
//  id_valid     in   1   ID holds a real instruction
//  id_ctrl      in   16  control bundle, bit order per ctrl_pkg
//  id_rs        in   5   source reg rs
//  id_rt        in   5   source reg rt
//  id_rd        in   5   rd field
//  id_use_rs    in   1   ID instruction reads rs
//  id_use_rt    in   1   ID instruction reads rt
//  ex_redirect  in   1   taken branch/jump/jr resolved in EX this cycle
//  ex_valid     out  1   EX stage valid
//  ex_ctrl      out  16  EX stage control
//  ex_rs        out  5   EX rs, for forwarding
//  ex_rt        out  5   EX rt, for forwarding
//  ex_dest      out  5   EX destination register
//  mem_valid    out  1   MEM stage valid
//  mem_ctrl     out  16  MEM stage control
//  mem_dest     out  5   MEM destination register
//  wb_valid     out  1   WB stage valid
//  wb_ctrl      out  16  WB stage control
//  wb_dest      out  5   WB destination register
//  fwd_a        out  2   EX rs select: 00 regfile, 01 MEM, 10 WB
//  fwd_b        out  2   EX rt select, same encoding
//  stall_fd     out  1   hold PC and IF/ID
//  flush_fd     out  1   clear IF/ID
//  mul_busy     out  1   mult/div holding EX
// BEHAVIOUR
//  Reset:
//  - While rst_n=0 at an edge: all valids 0, all ctrl/dest/rs/rt 0, mul counter 0.
//  - While rst_n=0, fwd_a/b=00 and stall_fd/flush_fd/mul_busy=0 combinationally.
//  Bubbles and destination:
//  - A bubble stores valid=0 and ctrl=0, so invalid stages never assert we_reg/we_dm/wehi/welo.
//  - dest at ID->EX: jal ? 31 : reg_dst ? rd : rt.
//  Producer rule (forwarding and load-use): a stage counts as a producer only if
//  valid & we_reg & dest!=0.
//  Forwarding (combinational):
//  - fwd_a=01 if MEM producer & mem_dest==ex_rs; else 10 if WB producer & wb_dest==ex_rs;
//    else 00. MEM match wins.
//  - fwd_b is the same rule using ex_rt.
//  Load-use:
//  - Condition: EX producer with dm2reg, id_valid, and
//    (id_use_rs & ex_dest==id_rs | id_use_rt & ex_dest==id_rt).
//  - Response: stall_fd=1, ID/EX loads a bubble, EX/MEM and MEM/WB advance. Lasts exactly 1 cycle.
//  Mult/div (EX valid with wehi&welo both set):
//  - The instruction stays in EX for MUL_LAT cycles. mul_busy=1 while cnt < MUL_LAT-1.
//  - While busy: stall_fd=1, ID/EX holds, EX/MEM loads a bubble, MEM/WB advances, cnt++.
//  - cnt returns to 0 on the cycle the instruction leaves EX.
//  Redirect (ex_redirect=1):
//  - flush_fd=1, ID/EX loads a bubble, EX advances normally.
//  Priority: redirect > mul_busy > load-use. When redirect is set, stall_fd=0.
//  Normal advance: each stage takes the previous stage every cycle; latency ID->WB is 3 cycles.
//  Reset mid-operation: sync reset clears an in-flight mult counter and all stages.
//  Pending stalls are dropped.
// STRUCTURE
//  - ctrl_pkg: CTRL_W=16 and bit indices BRANCH, JUMP, REG_DST, WE_REG, ALU_SRC, WE_DM, DM2REG,
//    ALU_CTRL[2:0], JAL, WEHI, WELO, JR, WB_CNTRL, SHIFT; FWD_REG/FWD_MEM/FWD_WB encodings;
//    RA_REG=31.
//  - One sub-module, hazard_fwd_unit: purely combinational forwarding, load-use and priority logic.
//    The stage registers and the mul counter live in ctrl_pipe.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with id_valid=1 -> all valids 0, fwd 00, stall/flush 0.
//  2. add $3,$1,$2; sub $4,$3,$1; or $5,$3,$0 -> sub in EX gives fwd_a=01;
//     or in EX gives fwd_a=10, fwd_b=00.
//  3. lw $5; add $6,$5,$5 -> stall_fd=1 for exactly 1 cycle, ex_valid=0 next cycle,
//     then fwd_a=fwd_b=10.
//  4. MUL_LAT=4, mult; mfhi -> mul_busy=1 for 3 cycles, 3 MEM bubbles;
//     mfhi enters EX the cycle after mult leaves.
//  5. jal then ex_redirect=1 -> flush_fd=1, next ex_valid=0; jal reaches WB with wb_dest=31.
//  6. addi $0,$1,5; add $2,$0,$0 -> fwd 00, no stall; MEM/WB ctrl of a bubble all 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Control bundle layout, forwarding encodings and stage record shared by the pipe.
package ctrl_pkg;
  localparam int CTRL_W      = 16;
  localparam int BRANCH      = 0;
  localparam int JUMP        = 1;
  localparam int REG_DST     = 2;
  localparam int WE_REG      = 3;
  localparam int ALU_SRC     = 4;
  localparam int WE_DM       = 5;
  localparam int DM2REG      = 6;
  localparam int ALU_CTRL_LO = 7;
  localparam int ALU_CTRL_HI = 9;
  localparam int JAL         = 10;
  localparam int WEHI        = 11;
  localparam int WELO        = 12;
  localparam int JR          = 13;
  localparam int WB_CNTRL    = 14;
  localparam int SHIFT       = 15;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] RA_REG = 5'd31;

  // One stage register: a bubble is all-zero.
  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        dest;
  } stage_t;

  // A stage only produces a value if it is real, writes the regfile and not to $0.
  function automatic logic is_prod(logic vld, logic we, logic [4:0] dest);
    return vld & we & (dest != 5'd0);
  endfunction
endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Combinational forwarding selects, load-use / mult-div stall and redirect flush.
module hazard_fwd_unit
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CW      = 2
) (
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          ex_redirect,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_dm2reg,
  input  logic          ex_mul,
  input  logic [4:0]    ex_rs,
  input  logic [4:0]    ex_rt,
  input  logic [4:0]    ex_dest,
  input  logic          mem_valid,
  input  logic          mem_we,
  input  logic [4:0]    mem_dest,
  input  logic          wb_valid,
  input  logic          wb_we,
  input  logic [4:0]    wb_dest,
  input  logic [CW-1:0] mul_cnt,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall_fd,
  output logic          flush_fd,
  output logic          mul_busy,
  output logic          mul_act,
  output logic          idex_bubble,
  output logic          idex_hold,
  output logic          exmem_bubble
);
  logic mem_p, wb_p, ex_p, lu, busy;

  assign mem_p = is_prod(mem_valid, mem_we, mem_dest);
  assign wb_p  = is_prod(wb_valid, wb_we, wb_dest);
  assign ex_p  = is_prod(ex_valid, ex_we, ex_dest);
  assign lu    = ex_p & ex_dm2reg & id_valid &
                 ((id_use_rs & (ex_dest == id_rs)) | (id_use_rt & (ex_dest == id_rt)));
  assign busy  = ex_valid & ex_mul & (mul_cnt < CW'(MUL_LAT - 1));

  // Select sources and resolve redirect > mul_busy > load-use; everything quiet in reset.
  always_comb begin
    fwd_a        = FWD_REG;
    fwd_b        = FWD_REG;
    stall_fd     = 1'b0;
    flush_fd     = 1'b0;
    mul_busy     = 1'b0;
    mul_act      = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    if (rst_n) begin
      if (mem_p && mem_dest == ex_rs)     fwd_a = FWD_MEM;
      else if (wb_p && wb_dest == ex_rs)  fwd_a = FWD_WB;
      if (mem_p && mem_dest == ex_rt)     fwd_b = FWD_MEM;
      else if (wb_p && wb_dest == ex_rt)  fwd_b = FWD_WB;
      mul_busy = busy;
      if (ex_redirect) begin
        flush_fd    = 1'b1;
        idex_bubble = 1'b1;
      end else if (busy) begin
        stall_fd     = 1'b1;
        idex_hold    = 1'b1;
        exmem_bubble = 1'b1;
        mul_act      = 1'b1;
      end else if (lu) begin
        stall_fd    = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers plus the mult/div occupancy counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_redirect,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [4:0]        mem_dest,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        wb_dest,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_fd,
  output logic              flush_fd,
  output logic              mul_busy
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  stage_t        ex_q, mem_q, wb_q, id_s;
  logic [4:0]    ex_rs_q, ex_rt_q;
  logic [CW-1:0] cnt;
  logic          mul_act, idex_bubble, idex_hold, exmem_bubble;

  // ID bundle as it would enter EX; an invalid ID slot becomes a clean bubble.
  always_comb begin
    id_s = '0;
    if (id_valid) begin
      id_s.vld  = 1'b1;
      id_s.ctrl = id_ctrl;
      id_s.dest = id_ctrl[JAL] ? RA_REG : (id_ctrl[REG_DST] ? id_rd : id_rt);
    end
  end

  hazard_fwd_unit #(.MUL_LAT(MUL_LAT), .CW(CW)) u_hz (
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_redirect  (ex_redirect),
    .ex_valid     (ex_q.vld),
    .ex_we        (ex_q.ctrl[WE_REG]),
    .ex_dm2reg    (ex_q.ctrl[DM2REG]),
    .ex_mul       (ex_q.ctrl[WEHI] & ex_q.ctrl[WELO]),
    .ex_rs        (ex_rs_q),
    .ex_rt        (ex_rt_q),
    .ex_dest      (ex_q.dest),
    .mem_valid    (mem_q.vld),
    .mem_we       (mem_q.ctrl[WE_REG]),
    .mem_dest     (mem_q.dest),
    .wb_valid     (wb_q.vld),
    .wb_we        (wb_q.ctrl[WE_REG]),
    .wb_dest      (wb_q.dest),
    .mul_cnt      (cnt),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_fd     (stall_fd),
    .flush_fd     (flush_fd),
    .mul_busy     (mul_busy),
    .mul_act      (mul_act),
    .idex_bubble  (idex_bubble),
    .idex_hold    (idex_hold),
    .exmem_bubble (exmem_bubble)
  );

  // Advance, hold or bubble each stage register; count cycles a mult/div sits in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt     <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= exmem_bubble ? '0 : ex_q;
      if (idex_bubble) begin
        ex_q    <= '0;
        ex_rs_q <= '0;
        ex_rt_q <= '0;
      end else if (!idex_hold) begin
        ex_q    <= id_s;
        ex_rs_q <= id_valid ? id_rs : 5'd0;
        ex_rt_q <= id_valid ? id_rt : 5'd0;
      end
      cnt <= mul_act ? cnt + CW'(1) : '0;
    end
  end

  assign ex_valid  = ex_q.vld;
  assign ex_ctrl   = ex_q.ctrl;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_dest   = ex_q.dest;
  assign mem_valid = mem_q.vld;
  assign mem_ctrl  = mem_q.ctrl;
  assign mem_dest  = mem_q.dest;
  assign wb_valid  = wb_q.vld;
  assign wb_ctrl   = wb_q.ctrl;
  assign wb_dest   = wb_q.dest;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed hazard checks plus a WB scoreboard of every instruction expected to retire.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, id_valid, id_use_rs, id_use_rt, ex_redirect;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic              ex_valid, mem_valid, wb_valid, stall_fd, flush_fd, mul_busy;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]        ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic [1:0]        fwd_a, fwd_b;

  ctrl_pipe #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_redirect(ex_redirect),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .mem_valid(mem_valid), .mem_ctrl(mem_ctrl),
    .mem_dest(mem_dest), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
    .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_fd(stall_fd),
    .flush_fd(flush_fd), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic use_rs, use_rt;
    logic [4:0] dest;
  } ins_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0] dest;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CTRL_W-1:0] cb(input int b0, input int b1 = -1,
                                           input int b2 = -1, input int b3 = -1);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[b0] = 1'b1;
    if (b1 >= 0) c[b1] = 1'b1;
    if (b2 >= 0) c[b2] = 1'b1;
    if (b3 >= 0) c[b3] = 1'b1;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ins_t i, input bit push);
    id_valid  = 1'b1;
    id_ctrl   = i.ctrl;
    id_rs     = i.rs;
    id_rt     = i.rt;
    id_rd     = i.rd;
    id_use_rs = i.use_rs;
    id_use_rt = i.use_rt;
    if (push) sb.push_back({i.ctrl, i.dest});
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_ctrl = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0;
    #1;
  endtask

  // Retirement monitor: every real WB slot must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_ctrl", 32'(wb_ctrl), 32'(e.ctrl));
        chk("wb_dest", 32'(wb_dest), 32'(e.dest));
      end
    end
  end

  ins_t add3, sub4, or5, lw5, add6, mult, mfhi, jal_i, junk, addi0, add2;

  initial begin
    add3  = '{cb(REG_DST, WE_REG), 5'd1, 5'd2, 5'd3, 1, 1, 5'd3};
    sub4  = '{cb(REG_DST, WE_REG, ALU_CTRL_HI), 5'd3, 5'd1, 5'd4, 1, 1, 5'd4};
    or5   = '{cb(REG_DST, WE_REG, ALU_CTRL_LO), 5'd3, 5'd0, 5'd5, 1, 1, 5'd5};
    lw5   = '{cb(WE_REG, ALU_SRC, DM2REG), 5'd1, 5'd5, 5'd0, 1, 0, 5'd5};
    add6  = '{cb(REG_DST, WE_REG), 5'd5, 5'd5, 5'd6, 1, 1, 5'd6};
    mult  = '{cb(WEHI, WELO), 5'd1, 5'd2, 5'd0, 1, 1, 5'd2};
    mfhi  = '{cb(REG_DST, WE_REG, WB_CNTRL), 5'd0, 5'd0, 5'd7, 0, 0, 5'd7};
    jal_i = '{cb(JUMP, JAL, WE_REG), 5'd0, 5'd9, 5'd0, 0, 0, 5'd31};
    junk  = '{cb(REG_DST, WE_REG), 5'd8, 5'd9, 5'd10, 1, 1, 5'd10};
    addi0 = '{cb(WE_REG, ALU_SRC), 5'd1, 5'd0, 5'd0, 1, 0, 5'd0};
    add2  = '{cb(REG_DST, WE_REG), 5'd0, 5'd0, 5'd2, 1, 1, 5'd2};

    rst_n = 1'b0; ex_redirect = 1'b0;
    drive(add3, 0);
    step(); step();
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
    chk("rst_stall_flush", 32'({stall_fd, flush_fd, mul_busy}), 0);
    idle();
    rst_n = 1'b1;
    step();

    // RAW chain forwarded from MEM then WB
    drive(add3, 1); step();
    drive(sub4, 1); step();
    chk("sub_fwd_a", 32'(fwd_a), 32'(FWD_MEM));
    chk("sub_fwd_b", 32'(fwd_b), 32'(FWD_REG));
    drive(or5, 1); step();
    chk("or_fwd_a", 32'(fwd_a), 32'(FWD_WB));
    chk("or_fwd_b", 32'(fwd_b), 32'(FWD_REG));
    chk("or_dest", 32'(ex_dest), 5);
    idle(); step(); step(); step();

    // load-use: one stall cycle, bubble, then WB forwarding on both operands
    drive(lw5, 1); step();
    drive(add6, 1);
    chk("lu_stall", 32'(stall_fd), 1);
    step();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_stall_once", 32'(stall_fd), 0);
    step();
    chk("lu_ex_dest", 32'(ex_dest), 6);
    chk("lu_fwd", 32'({fwd_a, fwd_b}), 32'({FWD_WB, FWD_WB}));
    idle(); step(); step(); step();

    // mult/div occupies EX for 4 cycles, 3 of them busy
    drive(mult, 1); step();
    drive(mfhi, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mul_busy%0d", i), 32'({mul_busy, stall_fd}), 32'b11);
      if (i > 0) chk($sformatf("mul_mem_bub%0d", i), 32'(mem_valid), 0);
      step();
    end
    chk("mul_last_busy", 32'({mul_busy, stall_fd}), 0);
    chk("mul_last_ex", 32'(ex_ctrl), 32'(mult.ctrl));
    chk("mul_last_bub", 32'(mem_valid), 0);
    step();
    chk("mfhi_in_ex", 32'(ex_ctrl), 32'(mfhi.ctrl));
    chk("mult_in_mem", 32'(mem_ctrl), 32'(mult.ctrl));
    idle(); step(); step(); step();

    // jal + redirect flushes the ID slot and still retires to $31
    drive(jal_i, 1); step();
    drive(junk, 0);
    ex_redirect = 1'b1; #1;
    chk("rd_flush", 32'({flush_fd, stall_fd}), 32'b10);
    step();
    ex_redirect = 1'b0;
    idle();
    chk("rd_bubble", 32'(ex_valid), 0);
    chk("rd_mem_dest", 32'({mem_valid, mem_dest}), 32'({1'b1, 5'd31}));
    step();
    chk("rd_wb_dest", 32'({wb_valid, wb_dest}), 32'({1'b1, 5'd31}));
    step(); step();

    // writes to $0 never forward or stall; bubble stages carry zero control
    drive(addi0, 1); step();
    drive(add2, 1);
    chk("z0_stall", 32'(stall_fd), 0);
    step();
    chk("z0_fwd", 32'({fwd_a, fwd_b}), 0);
    idle(); step(); step();
    chk("bub_mem", 32'({mem_valid, mem_ctrl}), 0);
    step();
    chk("bub_wb", 32'({wb_valid, wb_ctrl}), 0);
    step();

    // reset in the middle of a mult clears its counter
    drive(mult, 0); step();
    idle(); step();
    rst_n = 1'b0; step();
    chk("mrst_busy", 32'({mul_busy, ex_valid}), 0);
    rst_n = 1'b1;
    drive(mult, 1); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mrst_busy%0d", i), 32'(mul_busy), 1);
      step();
    end
    chk("mrst_done", 32'(mul_busy), 0);
    step(); step(); step();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
